// File: rtl/reg_file_pkg.sv
// Shared definitions for the scoreboarded register file.
// Holds the default geometry, the address-width function and the helpers
// that locate a read port's slice inside the packed raddr/rdata vectors.
package reg_file_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int NRD_DEF   = 2;

    // Address width for a register count; a single register still needs one bit.
    function automatic int addr_width(input int nregs);
        if (nregs <= 1) begin
            return 1;
        end else begin
            return $clog2(nregs);
        end
    endfunction

    // Low bit of read port 'port' inside the packed raddr vector.
    function automatic int rd_addr_lo(input int port, input int aw);
        return port * aw;
    endfunction

    // Low bit of read port 'port' inside the packed rdata vector.
    function automatic int rd_data_lo(input int port, input int xlen);
        return port * xlen;
    endfunction

endpackage

// File: rtl/reg_file_if.sv
// Bundle of the register file's read, reserve, write-back and flush signals.
// master: issue/write-back side (drives addresses, data, requests)
// slave : the register file (returns rdata, rbusy, busy_cnt)
interface reg_file_if
    import reg_file_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = NRD_DEF
);
    localparam int AW = addr_width(NREGS);

    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      rbusy;
    logic                res_valid;
    logic [AW-1:0]       res_addr;
    logic                we;
    logic [AW-1:0]       waddr;
    logic [XLEN-1:0]     wdata;
    logic                flush;
    logic [AW:0]         busy_cnt;

    modport master (
        output raddr, res_valid, res_addr, we, waddr, wdata, flush,
        input  rdata, rbusy, busy_cnt
    );

    modport slave (
        input  raddr, res_valid, res_addr, we, waddr, wdata, flush,
        output rdata, rbusy, busy_cnt
    );

endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write tracker for the register file.
// Ports: clk, rst_n (sync, active-low); res_valid/res_addr reserve a register;
// we/waddr retire a pending write; flush clears every mark.
// Outputs: pending (one bit per register, bit 0 never set) and busy_cnt,
// a registered population count of pending kept incrementally.
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = addr_width(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             res_valid,
    input  logic [AW-1:0]    res_addr,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic             flush,
    output logic [NREGS-1:0] pending,
    output logic [AW:0]      busy_cnt
);
    localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

    logic [NREGS-1:0] pending_d, pending_q;
    logic [AW:0]      busy_cnt_d, busy_cnt_q;
    logic             set_s, clr_s, inc_s, dec_s;

    // Next pending vector and count: flush beats reserve, reserve beats write-back.
    always_comb begin
        set_s      = res_valid && (res_addr != {AW{1'b0}}) && !flush;
        clr_s      = we && (waddr != {AW{1'b0}});
        // A bit only changes the count when it actually flips.
        inc_s      = set_s && !pending_q[res_addr];
        dec_s      = clr_s && pending_q[waddr] && !(set_s && (res_addr == waddr));
        pending_d  = pending_q;
        busy_cnt_d = busy_cnt_q;
        if (flush) begin
            pending_d  = {NREGS{1'b0}};
            busy_cnt_d = {(AW+1){1'b0}};
        end else begin
            if (clr_s) begin
                pending_d[waddr] = 1'b0;
            end else begin
                pending_d = pending_d;
            end
            if (set_s) begin
                pending_d[res_addr] = 1'b1;
            end else begin
                pending_d = pending_d;
            end
            case ({inc_s, dec_s})
                2'b10:   busy_cnt_d = busy_cnt_q + CNT_ONE;
                2'b01:   busy_cnt_d = busy_cnt_q - CNT_ONE;
                default: busy_cnt_d = busy_cnt_q;
            endcase
        end
    end

    // Pending marks and count registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q  <= {NREGS{1'b0}};
            busy_cnt_q <= {(AW+1){1'b0}};
        end else begin
            pending_q  <= pending_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign pending  = pending_q;
    assign busy_cnt = busy_cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// Register file with write-back scoreboard.
// Ports: clk, rst_n (sync, active-low), bus (reg_file_if.slave):
// NRD combinational read ports (rdata/rbusy from raddr), reserve, write-back,
// flush, and the registered busy_cnt. x0 is hardwired to zero and never pending.
// BYPASS=1 forwards same-cycle write-back data to matching read ports.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NRD    = NRD_DEF,
    parameter int BYPASS = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    reg_file_if.slave  bus
);
    localparam int AW = addr_width(NREGS);

    logic [NREGS-1:0][XLEN-1:0] regs_d, regs_q;
    logic [NREGS-1:0]           pending_s;
    logic [AW:0]                busy_cnt_s;
    logic [NRD*XLEN-1:0]        rdata_s;
    logic [NRD-1:0]             rbusy_s;
    logic [AW-1:0]              rd_addr_s;
    logic                       hit_s;

    reg_scoreboard #(.NREGS(NREGS), .AW(AW)) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .res_valid (bus.res_valid),
        .res_addr  (bus.res_addr),
        .we        (bus.we),
        .waddr     (bus.waddr),
        .flush     (bus.flush),
        .pending   (pending_s),
        .busy_cnt  (busy_cnt_s)
    );

    // Write-back into the data array; x0 writes are dropped so it stays zero.
    always_comb begin
        regs_d = regs_q;
        if (bus.we && (bus.waddr != {AW{1'b0}})) begin
            regs_d[bus.waddr] = bus.wdata;
        end else begin
            regs_d = regs_q;
        end
    end

    // Data array registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Per-port read mux: x0 reads zero, a bypass hit forwards wdata and hides
    // the pending mark that this very write-back is about to clear.
    always_comb begin
        rdata_s   = '0;
        rbusy_s   = '0;
        rd_addr_s = {AW{1'b0}};
        hit_s     = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            rd_addr_s = bus.raddr[rd_addr_lo(i, AW) +: AW];
            hit_s     = (BYPASS != 0) && bus.we && (bus.waddr == rd_addr_s);
            if (rd_addr_s == {AW{1'b0}}) begin
                rdata_s[rd_data_lo(i, XLEN) +: XLEN] = {XLEN{1'b0}};
                rbusy_s[i]                           = 1'b0;
            end else if (hit_s) begin
                rdata_s[rd_data_lo(i, XLEN) +: XLEN] = bus.wdata;
                rbusy_s[i]                           = 1'b0;
            end else begin
                rdata_s[rd_data_lo(i, XLEN) +: XLEN] = regs_q[rd_addr_s];
                rbusy_s[i]                           = pending_s[rd_addr_s];
            end
        end
    end

    assign bus.rdata    = rdata_s;
    assign bus.rbusy    = rbusy_s;
    assign bus.busy_cnt = busy_cnt_s;

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_file_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus_a ();
    reg_file_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus_b ();

    reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
    reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

    // stimulus for the next cycle
    logic          t_rst_n, t_res_valid, t_we, t_flush;
    logic [AW-1:0] t_res_addr, t_waddr, t_ra0, t_ra1;
    logic [31:0]   t_wdata;

    typedef struct {
        logic [31:0] rd0, rd1, nb0, nb1;
        logic [1:0]  rbusy, nbbusy;
        logic [5:0]  cnt;
        int          step;
    } exp_t;
    exp_t exp_q[$];

    // reference model: architectural registers and pending set
    bit [31:0] m_regs [NREGS];
    bit        m_pend [NREGS];
    int vectors = 0;
    int miscompares = 0;
    int step_no = 0;

    function automatic logic [31:0] exp_rd(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return 32'h0;
        if (byp && t_we && t_waddr == a) return t_wdata;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return 1'b0;
        if (byp && t_we && t_waddr == a) return 1'b0;
        return m_pend[a];
    endfunction

    function automatic logic [5:0] pend_count();
        int n = 0;
        for (int k = 0; k < NREGS; k++) n += int'(m_pend[k]);
        return 6'(n);
    endfunction

    task automatic idle();
        t_rst_n = 1'b1; t_res_valid = 1'b0; t_res_addr = '0; t_we = 1'b0;
        t_waddr = '0; t_wdata = 32'h0; t_flush = 1'b0; t_ra0 = '0; t_ra1 = '0;
    endtask

    task automatic drive_bus();
        bus_a.raddr = {t_ra1, t_ra0};    bus_b.raddr = {t_ra1, t_ra0};
        bus_a.res_valid = t_res_valid;   bus_b.res_valid = t_res_valid;
        bus_a.res_addr = t_res_addr;     bus_b.res_addr = t_res_addr;
        bus_a.we = t_we;                 bus_b.we = t_we;
        bus_a.waddr = t_waddr;           bus_b.waddr = t_waddr;
        bus_a.wdata = t_wdata;           bus_b.wdata = t_wdata;
        bus_a.flush = t_flush;           bus_b.flush = t_flush;
        rst_n = t_rst_n;
    endtask

    // apply one cycle of stimulus, queue what the outputs must show, advance the model
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        drive_bus();
        step_no++;
        e.rd0 = exp_rd(t_ra0, 1'b1);  e.rd1 = exp_rd(t_ra1, 1'b1);
        e.nb0 = exp_rd(t_ra0, 1'b0);  e.nb1 = exp_rd(t_ra1, 1'b0);
        e.rbusy  = {exp_busy(t_ra1, 1'b1), exp_busy(t_ra0, 1'b1)};
        e.nbbusy = {exp_busy(t_ra1, 1'b0), exp_busy(t_ra0, 1'b0)};
        e.cnt = pend_count();
        e.step = step_no;
        exp_q.push_back(e);
        if (!t_rst_n) begin
            for (int k = 0; k < NREGS; k++) begin m_regs[k] = 32'h0; m_pend[k] = 1'b0; end
        end else begin
            if (t_we && t_waddr != 0) begin
                m_regs[t_waddr] = t_wdata;
                m_pend[t_waddr] = 1'b0;
            end
            if (t_flush) begin
                for (int k = 0; k < NREGS; k++) m_pend[k] = 1'b0;
            end else if (t_res_valid && t_res_addr != 0) begin
                m_pend[t_res_addr] = 1'b1;
            end
        end
    endtask

    task automatic chk(input string name, input int stp, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s step %0d: got %h expected %h", name, stp, act, req);
        end
    endtask

    // monitor: outputs are settled mid-cycle, compare against the queued expectation
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            vectors++;
            chk("rdata0",      e.step, bus_a.rdata[31:0],        e.rd0);
            chk("rdata1",      e.step, bus_a.rdata[63:32],       e.rd1);
            chk("rbusy",       e.step, 32'(bus_a.rbusy),         32'(e.rbusy));
            chk("busy_cnt",    e.step, 32'(bus_a.busy_cnt),      32'(e.cnt));
            chk("nb_rdata0",   e.step, bus_b.rdata[31:0],        e.nb0);
            chk("nb_rdata1",   e.step, bus_b.rdata[63:32],       e.nb1);
            chk("nb_rbusy",    e.step, 32'(bus_b.rbusy),         32'(e.nbbusy));
            chk("nb_busy_cnt", e.step, 32'(bus_b.busy_cnt),      32'(e.cnt));
        end
    end

    initial begin
        idle();
        t_rst_n = 1'b0;
        drive_bus();
        repeat (2) @(posedge clk);
        for (int k = 0; k < NREGS; k++) begin m_regs[k] = 32'h0; m_pend[k] = 1'b0; end

        // write then read back; x0 reads zero
        idle(); step();
        idle(); t_we = 1'b1; t_waddr = 5'd5; t_wdata = 32'hDEADBEEF; step();
        idle(); t_ra0 = 5'd5; t_ra1 = 5'd0; step();
        // same-cycle forwarding vs. no forwarding
        idle(); t_we = 1'b1; t_waddr = 5'd7; t_wdata = 32'h1234; t_ra0 = 5'd7; step();
        idle(); t_ra0 = 5'd7; step();
        // reserve, observe busy, retire
        idle(); t_res_valid = 1'b1; t_res_addr = 5'd3; step();
        idle(); t_ra0 = 5'd3; step();
        idle(); t_we = 1'b1; t_waddr = 5'd3; t_wdata = 32'h33; t_ra0 = 5'd3; step();
        idle(); t_ra0 = 5'd3; step();
        // reserve and write the same register together
        idle(); t_res_valid = 1'b1; t_res_addr = 5'd9; t_we = 1'b1; t_waddr = 5'd9; t_wdata = 32'hA5; step();
        idle(); t_ra0 = 5'd9; t_ra1 = 5'd9; step();
        // reserve x1..x4, then flush with a competing reserve
        for (int r = 1; r <= 4; r++) begin
            idle(); t_res_valid = 1'b1; t_res_addr = AW'(r); step();
        end
        idle(); t_res_valid = 1'b1; t_res_addr = 5'd4; t_ra0 = 5'd4; step();
        idle(); t_flush = 1'b1; t_res_valid = 1'b1; t_res_addr = 5'd6; t_ra0 = 5'd1; t_ra1 = 5'd6; step();
        idle(); t_ra0 = 5'd6; t_ra1 = 5'd1; step();
        // reserve, write x0, then reset
        idle(); t_res_valid = 1'b1; t_res_addr = 5'd2; step();
        idle(); t_we = 1'b1; t_waddr = 5'd0; t_wdata = 32'hFF; t_ra0 = 5'd0; step();
        idle(); t_rst_n = 1'b0; t_res_valid = 1'b1; t_res_addr = 5'd8; t_we = 1'b1; t_waddr = 5'd5;
        t_wdata = 32'h55; t_ra0 = 5'd2; step();
        idle(); t_ra0 = 5'd0; t_ra1 = 5'd2; step();
        idle(); t_ra0 = 5'd5; t_ra1 = 5'd9; step();

        // randomized traffic, reads biased toward the write address
        for (int n = 0; n < 800; n++) begin
            idle();
            t_rst_n     = ($urandom_range(0, 99) != 0);
            t_res_valid = ($urandom_range(0, 1) == 1);
            t_res_addr  = AW'($urandom_range(0, NREGS - 1));
            t_we        = ($urandom_range(0, 2) != 0);
            t_waddr     = ($urandom_range(0, 3) == 0) ? t_res_addr : AW'($urandom_range(0, NREGS - 1));
            t_wdata     = $urandom;
            t_flush     = ($urandom_range(0, 15) == 0);
            t_ra0       = ($urandom_range(0, 2) == 0) ? t_waddr : AW'($urandom_range(0, NREGS - 1));
            t_ra1       = ($urandom_range(0, 3) == 0) ? t_ra0   : AW'($urandom_range(0, NREGS - 1));
            step();
        end
        idle(); step();

        // the monitor must drain everything within a few cycles
        repeat (4) @(negedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
